array_42_arb: RTL

Two-requester controller for the 4096x20 single-port masked SRAM macro (`RW0_*` port, 4x5-bit write mask, 1-cycle read latency). After reset, and on request, it zero-fills the whole array. It then shares the single RW port between two requesters with round-robin arbitration. It sits between the macro instance and its two client pipelines and is the only block that drives the macro.

---
 rtl/array_42_pkg.sv | 22 ++
 rtl/array_42_rr_arb.sv | 37 +++
 rtl/array_42_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/array_42_pkg.sv
// Shared constants and types for the two-requester SRAM controller
// in front of the 4096x20 masked single-port macro.
package array_42_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int MASK_W = 4;
    localparam int DEPTH  = 4096;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/array_42_rr_arb.sv
// Two-way round-robin arbiter; priority flips to the loser after every grant.
module array_42_rr_arb (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = 2'b00;
        prio_d  = prio_q;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o[prio_q] = 1'b1;
                default: grant_o = 2'b00;
            endcase
        end
        if (grant_o != 2'b00) begin
            prio_d = ~grant_o[1];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/array_42_arb.sv
// Zero-fills the SRAM macro after reset or clear, then shares its single
// RW port between two requesters with round-robin arbitration.
module array_42_arb
    import array_42_pkg::*;
(
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         clear_i,
    output logic                         init_done_o,
    input  logic [1:0]                   req_valid_i,
    output logic [1:0]                   req_ready_o,
    input  logic [1:0]                   req_write_i,
    input  logic [1:0][ADDR_W-1:0]       req_addr_i,
    input  logic [1:0][MASK_W-1:0]       req_wmask_i,
    input  logic [1:0][DATA_W-1:0]       req_wdata_i,
    output logic [1:0]                   resp_valid_o,
    output logic [1:0][DATA_W-1:0]       resp_rdata_o,
    output logic                         sram_en_o,
    output logic                         sram_wmode_o,
    output logic [ADDR_W-1:0]            sram_addr_o,
    output logic [MASK_W-1:0]            sram_wmask_o,
    output logic [DATA_W-1:0]            sram_wdata_o,
    input  logic [DATA_W-1:0]            sram_rdata_i
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              rd_pending_q, rd_pending_d;
    logic              rd_port_q, rd_port_d;

    req_t              req [2];
    req_t              req_sel;
    logic              arb_en;
    logic [1:0]        grant;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req[gi] = '{write: req_write_i[gi],
                               addr:  req_addr_i[gi],
                               wmask: req_wmask_i[gi],
                               wdata: req_wdata_i[gi]};
            assign resp_valid_o[gi] = rd_pending_q && (rd_port_q == 1'(gi));
            assign resp_rdata_o[gi] = sram_rdata_i;
        end
    endgenerate

    // clear suppresses grants in the same cycle it is seen
    assign arb_en      = (state_q == RUN) && !clear_i;
    assign req_ready_o = grant;
    assign init_done_o = (state_q == RUN);
    assign req_sel     = grant[1] ? req[1] : req[0];

    array_42_rr_arb u_rr_arb (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .valid_i   (req_valid_i),
        .en_i      (arb_en),
        .grant_o   (grant)
    );

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        sram_en_o    = 1'b0;
        sram_wmode_o = 1'b0;
        sram_addr_o  = '0;
        sram_wmask_o = '0;
        sram_wdata_o = '0;
        rd_pending_d = 1'b0;
        rd_port_d    = rd_port_q;

        case (state_q)
            INIT: begin
                sram_en_o    = 1'b1;
                sram_wmode_o = 1'b1;
                sram_wmask_o = '1;
                sram_addr_o  = fill_cnt_q;
                fill_cnt_d   = fill_cnt_q + 1'b1;
                if (fill_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (grant != 2'b00) begin
                    sram_en_o    = 1'b1;
                    sram_wmode_o = req_sel.write;
                    sram_addr_o  = req_sel.addr;
                    sram_wmask_o = req_sel.wmask;
                    sram_wdata_o = req_sel.wdata;
                    rd_pending_d = !req_sel.write;
                    rd_port_d    = grant[1];
                end
            end
            default: state_d = INIT;
        endcase

        if (clear_i) begin
            state_d    = INIT;
            fill_cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= INIT;
            fill_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            rd_port_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_port_q    <= rd_port_d;
        end
    end

endmodule
